tag_verify: RTL and testbench

//   Decryption-side counterpart of the downstream XOR / tag-extraction stage.

---
 rtl/tag_verify_pkg.sv | 14 +
 rtl/tag_verify.sv | 113 +++++++++++
 tb/tb_tag_verify.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tag_verify_pkg.sv
// Shared constants and FSM encoding for the decryption-side tag comparator.
package tag_verify_pkg;

    localparam int TAG_W      = 128;
    localparam int TAG_WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } type_tag_fsm;

endpackage

// File: rtl/tag_verify.sv
// Collects the computed Ascon tag and the two received tag words, then compares them
// in constant time and reports a one-cycle done pulse plus a held pass/fail flag.
module tag_verify #(
    parameter int WORD_W = tag_verify_pkg::TAG_WORD_W,
    parameter int TAG_W  = tag_verify_pkg::TAG_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              tag_calc_valid_i,
    input  logic [TAG_W-1:0]  tag_calc_i,
    input  logic              tag_word_valid_i,
    input  logic [WORD_W-1:0] tag_word_i,
    output logic              tag_word_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              tag_ok_o
);
    import tag_verify_pkg::*;

    type_tag_fsm       state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              seen_q, seen_d;
    logic [TAG_W-1:0]  calc_q, calc_d;
    logic [TAG_W-1:0]  exp_q, exp_d;
    logic              ok_q, ok_d;

    logic              word_ready;
    logic              word_fire;
    logic              mismatch;

    assign word_ready = (state_q == COLLECT) && (cnt_q < 2'd2);
    assign word_fire  = word_ready && tag_word_valid_i;

    // Full-width reduction: every bit always participates, so timing never depends on data.
    assign mismatch = |(calc_q ^ exp_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        calc_d  = calc_q;
        exp_d   = exp_q;
        ok_d    = ok_q;

        unique case (state_q)
            IDLE: begin
            end
            COLLECT: begin
                if (word_fire) begin
                    if (cnt_q == 2'd0) begin
                        exp_d[TAG_W-1:WORD_W] = tag_word_i;
                    end else begin
                        exp_d[WORD_W-1:0] = tag_word_i;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                if (tag_calc_valid_i && !seen_q) begin
                    calc_d = tag_calc_i;
                    seen_d = 1'b1;
                end
                // Looking at the post-edge values lets a final capture move straight to CHECK.
                if ((cnt_d == 2'd2) && seen_d) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                ok_d    = ~mismatch;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start aborts whatever is in flight and discards all captured data.
        if (start_i) begin
            state_d = COLLECT;
            cnt_d   = 2'd0;
            seen_d  = 1'b0;
            ok_d    = 1'b0;
            calc_d  = '0;
            exp_d   = '0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            seen_q  <= 1'b0;
            calc_q  <= '0;
            exp_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            calc_q  <= calc_d;
            exp_q   <= exp_d;
            ok_q    <= ok_d;
        end
    end

    assign tag_word_ready_o = word_ready;
    assign busy_o           = (state_q == COLLECT) || (state_q == CHECK);
    assign done_o           = (state_q == DONE);
    assign tag_ok_o         = ok_q;

endmodule

// File: tb/tb_tag_verify.sv
// Directed, table-driven bench for tag_verify: capture orders, latency, backpressure,
// restart, asynchronous reset and result hold.
module tb_tag_verify;

    logic         clk;
    logic         rst;
    logic         start;
    logic         calc_valid;
    logic [127:0] calc;
    logic         word_valid;
    logic [63:0]  word;
    logic         ready;
    logic         busy;
    logic         done;
    logic         ok;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [127:0] calc;
        logic [63:0]  w0;
        logic [63:0]  w1;
        int           mode;  // 0 calc,w0,w1  1 w0,w1,calc  2 w0,{w1+calc}  3 {w0+calc},w1
        logic         ok;
    } vec_t;

    vec_t vecs[8];

    tag_verify dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .start_i          (start),
        .tag_calc_valid_i (calc_valid),
        .tag_calc_i       (calc),
        .tag_word_valid_i (word_valid),
        .tag_word_i       (word),
        .tag_word_ready_o (ready),
        .busy_o           (busy),
        .done_o           (done),
        .tag_ok_o         (ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One clock of stimulus; a word offered here is expected to be accepted.
    task automatic drive(input logic cv, input logic [127:0] c, input logic wv, input logic [63:0] w);
        calc_valid = cv;
        calc       = c;
        word_valid = wv;
        word       = w;
        if (wv) chk("ready_for_word", {127'd0, ready}, 128'd1);
        @(posedge clk); #1;
        calc_valid = 1'b0;
        word_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called #1 after the final capture edge: expects CHECK, then DONE, then IDLE.
    task automatic expect_result(input string tag, input logic exp_ok);
        chk({tag, "_check_busy"}, {127'd0, busy}, 128'd1);
        chk({tag, "_check_nodone"}, {127'd0, done}, 128'd0);
        @(posedge clk); #1;
        chk({tag, "_done"}, {127'd0, done}, 128'd1);
        chk({tag, "_ok"}, {127'd0, ok}, {127'd0, exp_ok});
        chk({tag, "_done_busy"}, {127'd0, busy}, 128'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse_end"}, {127'd0, done}, 128'd0);
        chk({tag, "_ok_held"}, {127'd0, ok}, {127'd0, exp_ok});
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        pulse_start();
        chk({tag, "_start_busy"}, {127'd0, busy}, 128'd1);
        chk({tag, "_start_ok_clr"}, {127'd0, ok}, 128'd0);
        case (v.mode)
            0: begin
                drive(1'b1, v.calc, 1'b0, 64'd0);
                drive(1'b0, 128'd0, 1'b1, v.w0);
                chk({tag, "_wait_nodone"}, {127'd0, done}, 128'd0);
                drive(1'b0, 128'd0, 1'b1, v.w1);
            end
            1: begin
                drive(1'b0, 128'd0, 1'b1, v.w0);
                drive(1'b0, 128'd0, 1'b1, v.w1);
                chk({tag, "_full_noready"}, {127'd0, ready}, 128'd0);
                drive(1'b1, v.calc, 1'b0, 64'd0);
            end
            2: begin
                drive(1'b0, 128'd0, 1'b1, v.w0);
                drive(1'b1, v.calc, 1'b1, v.w1);
            end
            default: begin
                drive(1'b1, v.calc, 1'b1, v.w0);
                drive(1'b0, 128'd0, 1'b1, v.w1);
            end
        endcase
        expect_result(tag, v.ok);
    endtask

    initial begin
        vecs[0] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0, 1'b1};
        vecs[1] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 64'h0123456789ABCDEF, 64'hFEDCBA9876543211, 0, 1'b0};
        vecs[2] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1, 1'b1};
        vecs[3] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2, 1'b1};
        vecs[4] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 64'h8123456789ABCDEF, 64'hFEDCBA9876543210, 1, 1'b0};
        vecs[5] = '{128'h0, 64'h0, 64'h0, 3, 1'b1};
        vecs[6] = '{{128{1'b1}}, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFF, 2, 1'b0};
        vecs[7] = '{128'hDEADBEEFCAFEF00D_0BADC0DE12345678, 64'hDEADBEEFCAFEF00D, 64'h0BADC0DE12345678, 3, 1'b1};

        rst = 1'b1; start = 1'b0; calc_valid = 1'b0; calc = '0; word_valid = 1'b0; word = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {127'd0, ready}, 128'd0);
        chk("reset_busy",  {127'd0, busy},  128'd0);
        chk("reset_done",  {127'd0, done},  128'd0);
        chk("reset_ok",    {127'd0, ok},    128'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ignores_word", {127'd0, ready}, 128'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Third word held valid after two accepted: must stay unaccepted, exp untouched.
        pulse_start();
        drive(1'b0, 128'd0, 1'b1, 64'h0123456789ABCDEF);
        drive(1'b0, 128'd0, 1'b1, 64'hFEDCBA9876543210);
        word_valid = 1'b1;
        word       = 64'h5555AAAA5555AAAA;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", {127'd0, ready}, 128'd0);
            @(posedge clk); #1;
            chk("bp_still_busy", {127'd0, busy}, 128'd1);
        end
        word_valid = 1'b0;
        drive(1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 64'd0);
        expect_result("bp", 1'b1);

        // Second calc pulse with a different value must be ignored.
        pulse_start();
        drive(1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 64'd0);
        drive(1'b1, 128'hFFFF0000FFFF0000_FFFF0000FFFF0000, 1'b0, 64'd0);
        drive(1'b0, 128'd0, 1'b1, 64'h0123456789ABCDEF);
        drive(1'b0, 128'd0, 1'b1, 64'hFEDCBA9876543210);
        expect_result("calc2", 1'b1);

        // Restart after one junk word: count must be cleared for the new run.
        pulse_start();
        drive(1'b0, 128'd0, 1'b1, 64'h1111111111111111);
        run_vec(100, vecs[0]);

        // Hold: pass result stays up while idle, then start clears it on that edge.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("hold_ok", {127'd0, ok}, 128'd1);
        chk("hold_idle_busy", {127'd0, busy}, 128'd0);
        pulse_start();
        chk("hold_start_clears_ok", {127'd0, ok}, 128'd0);

        // Asynchronous reset between edges, mid-COLLECT.
        drive(1'b0, 128'd0, 1'b1, 64'h0123456789ABCDEF);
        chk("pre_rst_ready", {127'd0, ready}, 128'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", {127'd0, ready}, 128'd0);
        chk("arst_busy",  {127'd0, busy},  128'd0);
        chk("arst_done",  {127'd0, done},  128'd0);
        chk("arst_ok",    {127'd0, ok},    128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {127'd0, busy}, 128'd0);
        run_vec(200, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
